mod_scheduler: RTL and testbench

Shares one bit-serial modulo datapath between two requesters. Round-robin arbitration grants one request at a time, captures its operands, and runs a restoring shift-subtract remainder over DATAWIDTH cycles. The result is returned on a valid/ready response port tagged with the requester id. It sits between the client blocks that need `a % b` and replaces per-client combinational MOD instances where area matters more than latency.

---
 rtl/mod_scheduler.sv | 117 +++++++++++
 tb/tb_mod_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_scheduler.sv
// Two-requester round-robin front end for one bit-serial restoring remainder unit.
// Optional build macro MOD_SCHED_DZ_BYPASS_EN: zero divisors skip the iterations and flag rsp_dz.
module mod_scheduler #(
  parameter int DATAWIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [2*DATAWIDTH-1:0] req_a,
  input  logic [2*DATAWIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [DATAWIDTH-1:0]   rsp_rem,
  output logic                   rsp_dz
);

  localparam int CW = $clog2(DATAWIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               r_state;
  logic                 r_last_id;
  logic                 r_id;
  logic [DATAWIDTH-1:0] r_a;
  logic [DATAWIDTH-1:0] r_b;
  logic [DATAWIDTH-1:0] r_rem;
  logic [CW-1:0]        r_cnt;

  logic [1:0]           w_grant;
  logic                 w_acc;
  logic                 w_acc_id;
  logic [DATAWIDTH-1:0] w_sel_a;
  logic [DATAWIDTH-1:0] w_sel_b;
  logic [DATAWIDTH:0]   w_t;
  logic                 w_ge;
  logic [DATAWIDTH-1:0] w_diff;

  // On a tie the requester that was not served last wins.
  always_comb begin
    w_grant = req_valid;
    if (&req_valid) w_grant = r_last_id ? 2'b01 : 2'b10;
  end

  assign req_ready = (r_state == S_IDLE) ? w_grant : 2'b00;
  assign w_acc     = |req_ready;
  assign w_acc_id  = req_ready[1];
  assign w_sel_a   = w_acc_id ? req_a[DATAWIDTH +: DATAWIDTH] : req_a[0 +: DATAWIDTH];
  assign w_sel_b   = w_acc_id ? req_b[DATAWIDTH +: DATAWIDTH] : req_b[0 +: DATAWIDTH];

  // The partial remainder is always < b, so the subtraction result and the
  // pass-through value both fit in DATAWIDTH bits; only the compare needs the carry bit.
  assign w_t    = {r_rem, r_a[r_cnt]};
  assign w_ge   = (w_t >= {1'b0, r_b});
  assign w_diff = w_t[DATAWIDTH-1:0] - r_b;

`ifdef MOD_SCHED_DZ_BYPASS_EN
  logic r_dz;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last_id <= 1'b1;
      r_id      <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
`ifdef MOD_SCHED_DZ_BYPASS_EN
      r_dz      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_a       <= w_sel_a;
            r_b       <= w_sel_b;
            r_id      <= w_acc_id;
            r_last_id <= w_acc_id;
            r_rem     <= '0;
            r_cnt     <= CW'(DATAWIDTH - 1);
            r_state   <= S_BUSY;
`ifdef MOD_SCHED_DZ_BYPASS_EN
            r_dz      <= 1'b0;
            if (w_sel_b == '0) begin
              r_rem   <= w_sel_a;
              r_dz    <= 1'b1;
              r_state <= S_DONE;
            end
`endif
          end
        end
        S_BUSY: begin
          r_rem <= w_ge ? w_diff : w_t[DATAWIDTH-1:0];
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= S_DONE;
        end
        S_DONE: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = (r_state == S_DONE);
  assign rsp_id    = r_id;
  assign rsp_rem   = r_rem;
`ifdef MOD_SCHED_DZ_BYPASS_EN
  assign rsp_dz    = r_dz;
`else
  assign rsp_dz    = 1'b0;
`endif

endmodule

// File: tb/tb_mod_scheduler.sv
// Scoreboard bench for mod_scheduler: a transaction-level model predicts grants,
// response timing and a % b results; a negedge monitor compares against the DUT.
module tb_mod_scheduler;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     req_valid = 2'b00;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_a = '0;
  logic [2*W-1:0] req_b = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic           rsp_id;
  logic [W-1:0]   rsp_rem;
  logic           rsp_dz;

  mod_scheduler #(.DATAWIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_rem(rsp_rem), .rsp_dz(rsp_dz)
  );

  always #5 clk = ~clk;

  typedef struct { logic id; logic [W-1:0] rem; logic dz; } exp_t;
  typedef struct { logic [W-1:0] a; logic [W-1:0] b; } op_t;

  exp_t sb[$];
  op_t  pq[2][$];

  int checks = 0;
  int errors = 0;

  // Model state: 0 = free, 1 = computing, 2 = holding a response
  int         m_st   = 0;
  int         m_left = 0;
  logic       m_last = 1'b1;
  logic [1:0] m_acc  = 2'b00;
  bit         m_on   = 1'b0;

  int  hold    = 0;
  bit  gap_mode = 1'b0;
  bit  rnd_rdy  = 1'b0;

  function automatic logic [W-1:0] ref_rem(logic [W-1:0] a, logic [W-1:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  function automatic logic ref_dz(logic [W-1:0] b);
`ifdef MOD_SCHED_DZ_BYPASS_EN
    return (b == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int ref_cycles(logic [W-1:0] b);
`ifdef MOD_SCHED_DZ_BYPASS_EN
    if (b == 0) return 1;
`endif
    return W;
  endfunction

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model advances on each rising edge from the pre-edge inputs.
  always @(posedge clk) begin
    int         w;
    logic [W-1:0] a, b;
    m_acc <= 2'b00;
    if (rst) begin
      m_st   <= 0;
      m_last <= 1'b1;
      m_on   <= 1'b1;
      sb.delete();
    end else if (m_st == 0) begin
      if (req_valid != 2'b00) begin
        if (req_valid == 2'b11) w = m_last ? 0 : 1;
        else                    w = req_valid[1] ? 1 : 0;
        a = req_a[w*W +: W];
        b = req_b[w*W +: W];
        sb.push_back('{id: w[0], rem: ref_rem(a, b), dz: ref_dz(b)});
        m_last   <= w[0];
        m_acc[w] <= 1'b1;
        if (ref_cycles(b) == 1) m_st <= 2;
        else begin
          m_st   <= 1;
          m_left <= W;
        end
      end
    end else if (m_st == 1) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_st <= 2;
    end else begin
      if (rsp_ready) m_st <= 0;
    end
  end

  // Monitor: timing/grant checks every cycle, scoreboard pop on handshake.
  always @(negedge clk) begin
    logic [1:0] er;
    exp_t e;
    if (m_on) begin
      chk("rsp_valid", W'(rsp_valid), W'(m_st == 2));
      er = 2'b00;
      if (m_st == 0) begin
        if (req_valid == 2'b11) er[~m_last] = 1'b1;
        else                    er = req_valid;
      end
      chk("req_ready", W'(req_ready), W'(er));
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got id %0d rem %h, expected no response", rsp_id, rsp_rem);
        end else begin
          e = sb[0];
          chk("rsp_id", W'(rsp_id), W'(e.id));
          chk("rsp_rem", rsp_rem, e.rem);
          chk("rsp_dz", W'(rsp_dz), W'(e.dz));
          if (rsp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  // Driver: presents queued ops, scrambles operands after accept, shapes rsp_ready.
  initial begin
    op_t op;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (m_acc[i]) begin
          req_valid[i]     = 1'b0;
          req_a[i*W +: W]  = $urandom;
          req_b[i*W +: W]  = $urandom;
        end
        if (!req_valid[i] && pq[i].size() > 0 && (!gap_mode || $urandom_range(0, 3) == 0)) begin
          op               = pq[i].pop_front();
          req_valid[i]     = 1'b1;
          req_a[i*W +: W]  = op.a;
          req_b[i*W +: W]  = op.b;
        end
      end
      if (m_st == 2 && hold > 0) begin
        rsp_ready = 1'b0;
        hold--;
      end else begin
        rsp_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  task automatic push(int id, logic [W-1:0] a, logic [W-1:0] b);
    pq[id].push_back('{a: a, b: b});
  endtask

  task automatic wait_idle(int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (pq[0].size() == 0 && pq[1].size() == 0 && req_valid == 2'b00 &&
          m_st == 0 && sb.size() == 0) begin
        checks++;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: got %0d responses pending, expected 0 within %0d cycles", sb.size(), budget);
  endtask

  initial begin
    logic [W-1:0] a, b;
    bit seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", W'(rsp_valid), '0);
    chk("reset_rsp_id", W'(rsp_id), '0);
    chk("reset_rsp_rem", rsp_rem, '0);
    chk("reset_rsp_dz", W'(rsp_dz), '0);
    chk("reset_req_ready", W'(req_ready), '0);

    // Ties from reset: ids must alternate 0,1,0,1,...
    push(0, 1000, 9);  push(1, 1000, 13);
    push(0, 100, 7);   push(1, 55, 6);
    push(0, 77, 10);   push(1, 99, 4);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    wait_idle(1000);

    push(0, 100, 7);
    wait_idle(200);

    push(0, 1, 32'h8000_0000);
    push(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push(0, 32'hFFFF_FFFE, 1);
    push(1, 0, 5);
    wait_idle(500);

    push(0, 32'h1234, 0);
    wait_idle(200);
    push(1, 32'hFFFF_FFFF, 0);
    wait_idle(200);

    // Backpressure with the other requester waiting
    hold = 5;
    push(0, 77, 5);
    push(1, 88, 9);
    wait_idle(300);

    // Reset part-way through an op: nothing may come out, tie then goes to 0
    push(1, 12345, 77);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      if (m_st == 1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got no BUSY phase, expected one within 20 cycles");
    end
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    push(0, 500, 7);
    push(1, 500, 11);
    wait_idle(300);

    // Randomized ops with random gaps and random backpressure
    gap_mode = 1'b1;
    rnd_rdy  = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 0;
        1:       b = 1;
        2:       b = $urandom_range(1, 15);
        3:       b = a;
        4:       b = 32'h8000_0000 | $urandom;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      push($urandom_range(0, 1), a, b);
    end
    wait_idle(80000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
